multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I-subset core. It replaces single-cycle control so that one ALU, one unified memory port and one register-file write port are shared across the cycles of each instruction.
- Sequences fetch/decode/execute/memory/writeback and drives all datapath mux selects and write strobes.
- Supports a memory request/ready handshake with unbounded wait states.

Parameters:
CNT_W, 32, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  memory completes the request this cycle
mem_req  out  1  memory access request, held until mem_ready
mem_write  out  1  request is a store (valid with mem_req)
adr_src  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  latch instruction register and old-PC register
pc_write  out  1  load PC from result bus
reg_write  out  1  register-file write
result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result direct
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1 reg
alu_src_b  out  2  00=rs2 reg, 01=imm, 10=constant 4
alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 I, 01 S, 10 B, 11 J (decoded from opcode, every state)
illegal  out  1  sticky: unsupported opcode reached DECODE
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - Asynchronous on rst_n low. State goes to IDLE and illegal clears to 0.
  - All outputs are 0 while in IDLE, except imm_src, which always follows opcode.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BEQ=10, JAL=11, HALT=15.
- Outputs are Moore-decoded from state. The only exceptions are the mem_ready-qualified strobes noted below. All strobes not listed for a state are 0.
- IDLE:
  - Always goes to FETCH next cycle. Exactly one dead cycle after reset release.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1. Go to DECODE then; otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, alu_ctrl=add, so that ALUOut holds the branch/jump target.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> HALT, with illegal set.
- MEMADR:
  - Drives alu_src_a=10, alu_src_b=01, alu_ctrl=add.
  - Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD:
  - Drives mem_req=1, adr_src=1.
  - Waits for mem_ready, then goes to MEMWB.
- MEMWB:
  - Drives result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE:
  - Drives mem_req=1, mem_write=1, adr_src=1.
  - Waits for mem_ready, then goes to FETCH.
- EXECR:
  - Drives alu_src_a=10, alu_src_b=00, alu_ctrl from the funct decode. Goes to ALUWB.
- EXECI:
  - Same as EXECR but alu_src_b=01. Goes to ALUWB.
- ALUWB:
  - Drives result_src=00, reg_write=1. Goes to FETCH.
- BEQ:
  - Drives alu_src_a=10, alu_src_b=00, alu_ctrl=sub, result_src=00, pc_write=zero. Goes to FETCH.
- JAL:
  - Drives alu_src_a=01, alu_src_b=10, alu_ctrl=add, result_src=00, pc_write=1. Goes to ALUWB, which writes oldPC+4 to rd.
- HALT:
  - Absorbing state; only reset exits it. All strobes are 0.
- funct decode (EXECR/EXECI):
  - funct3 000 -> add. Exception: sub when funct7b5=1 and opcode=0110011; immediate forms always add.
  - funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- mem_req stays asserted while waiting. mem_write and adr_src are stable for the whole request.
- Reset mid-request drops mem_req immediately (asynchronously).
- Cycle counts with zero wait states:
  - lw 5, sw 4, R/I 4, beq 3, jal 4.
  - Each mem_ready-low cycle adds 1.

Optional Feature:
- Macro name: PERF_CNT_EN.
- With the macro defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle when state is not IDLE or HALT.
  - instret_cnt increments on every transition into FETCH from a non-IDLE state.
  - Both counters wrap modulo 2^CNT_W.
- Without the macro: the ports and logic are absent.

Decomposition:
- Package ctrl_pkg contains:
  - state enum, 4-bit
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - alu_ctrl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - result_src, alu_src_a and alu_src_b select encodings
  - imm_src encodings
- One sub-module: alu_ctrl_dec, combinational, mapping (opcode, funct3, funct7b5) to alu_ctrl. The FSM overrides its output with add/sub in non-execute states.

Test Plan:
- Reset then lw (opcode 0000011), mem_ready=1 always -> states IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_write=1 with result_src=01 in MEMWB only.
- sw with mem_ready low 3 cycles in MEMWRITE -> mem_req=1 and mem_write=1 held 4 cycles, adr_src=1 throughout; FETCH reached the cycle after mem_ready.
- R-type funct3=000, funct7b5=1 -> alu_ctrl=001 in EXECR. I-type with same fields -> alu_ctrl=000 in EXECI.
- beq with zero=1 -> pc_write=1 in BEQ. With zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- Opcode 1110011 -> DECODE then HALT, illegal=1, no mem_req for 10 cycles; rst_n pulse -> illegal=0, state IDLE.
- PERF_CNT_EN: reset, run 2 back-to-back R-type instructions with zero wait -> instret_cnt=2 and cycle_cnt=8 on entry to the third FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_pkg : shared encodings for the multi-cycle RV32I control FSM     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_MEMADR   = 4'd3;
    localparam state_t ST_MEMREAD  = 4'd4;
    localparam state_t ST_MEMWB    = 4'd5;
    localparam state_t ST_MEMWRITE = 4'd6;
    localparam state_t ST_EXECR    = 4'd7;
    localparam state_t ST_EXECI    = 4'd8;
    localparam state_t ST_ALUWB    = 4'd9;
    localparam state_t ST_BEQ      = 4'd10;
    localparam state_t ST_JAL      = 4'd11;
    localparam state_t ST_HALT     = 4'd15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_ctrl_if : decode inputs, memory handshake and datapath     |
// | control bundle between controller (master) and datapath (slave)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal, state_o
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal, state_o
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ctrl_dec : funct3/funct7 to ALU operation for execute states      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_ctrl_o
);
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (funct3_i)
            // Immediate forms never subtract: instr[30] is part of the immediate there.
            3'b000:  if (funct7b5_i && (opcode_i == OP_R)) alu_ctrl_o = ALU_SUB;
            3'b010:  alu_ctrl_o = ALU_SLT;
            3'b110:  alu_ctrl_o = ALU_OR;
            3'b111:  alu_ctrl_o = ALU_AND;
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_ctrl : fetch/decode/execute/mem/writeback sequencer with   |
// | memory req/ready handshake. Optional counters under PERF_CNT_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_if.master    bus
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
`endif
);
    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [2:0] w_dec_alu;

    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b;
    logic [2:0] w_alu_ctrl;

    alu_ctrl_dec u_alu_ctrl_dec (
        .opcode_i   (bus.opcode),
        .funct3_i   (bus.funct3),
        .funct7b5_i (bus.funct7b5),
        .alu_ctrl_o (w_dec_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXECR;
                    OP_I:         state_d = ST_EXECI;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_JAL:       state_d = ST_JAL;
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEMADR:   state_d = (bus.opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (bus.mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: if (bus.mem_ready) state_d = ST_FETCH;
            ST_EXECR,
            ST_EXECI:    state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BEQ:      state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_ctrl   = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            // ALUOut captures oldPC+imm here so BEQ/JAL can use it as target.
            ST_DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            ST_MEMWB: begin
                w_result_src = RES_MEM;
                w_reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
            end
            ST_EXECR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_ctrl  = w_dec_alu;
            end
            ST_EXECI: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                w_alu_ctrl  = w_dec_alu;
            end
            ST_ALUWB:    w_reg_write = 1'b1;
            ST_BEQ: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_ctrl  = ALU_SUB;
                w_pc_write  = bus.zero;
            end
            ST_JAL: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_write  = w_mem_write;
    assign bus.adr_src    = w_adr_src;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.result_src = w_result_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_ctrl   = w_alu_ctrl;
    assign bus.imm_src    = imm_src_of(bus.opcode);
    assign bus.illegal    = illegal_q;
    assign bus.state_o    = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (state_q != ST_HALT))
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            // A FETCH->FETCH wait is not a new entry; IDLE->FETCH retires nothing.
            if ((state_d == ST_FETCH) && (state_q != ST_IDLE) && (state_q != ST_FETCH))
                instret_cnt_q <= instret_cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_ctrl : randomized instruction streams vs. trace model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multicycle_ctrl;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4,
                   S_MEMWB = 5, S_MEMWRITE = 6, S_EXECR = 7, S_EXECI = 8, S_ALUWB = 9,
                   S_BEQ = 10, S_JAL = 11, S_HALT = 15;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );
`else
    multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cycles  = 0;
    int exp_instret = 0;

    function automatic logic [6:0] opcode_of(input int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src, src_a, src_b, alu_ctrl}
    function automatic logic [14:0] ref_ctl(input int st, input logic rdy, input logic z,
                                            input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic req, wr, adr, irw, pcw, rw;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        {req, wr, adr, irw, pcw, rw} = 6'b0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        case (st)
            S_FETCH:    begin req = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  begin req = 1; adr = 1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1; end
            S_MEMWRITE: begin req = 1; wr = 1; adr = 1; end
            S_EXECR:    begin a = 2'b10; b = 2'b00; alu = ref_alu(op, f3, f7); end
            S_EXECI:    begin a = 2'b10; b = 2'b01; alu = ref_alu(op, f3, f7); end
            S_ALUWB:    begin rw = 1; end
            S_BEQ:      begin a = 2'b10; alu = 3'b001; pcw = z; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {req, wr, adr, irw, pcw, rw, rs, a, b, alu};
    endfunction

    function automatic logic [14:0] dut_ctl();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0; bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cycles = 0; exp_instret = 0;
    endtask

    // Drives one instruction starting in the first FETCH cycle; ends in the next FETCH cycle.
    task automatic run_instr(input string tag, input int kind, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw, input logic z);
        int sq[$];
        logic rq[$];
        logic [6:0] op;
        logic [21:0] exp_v, got_v;
        logic rdy, zz;
        op = opcode_of(kind);
        for (int i = 0; i < fw; i++) begin sq.push_back(S_FETCH); rq.push_back(1'b0); end
        sq.push_back(S_FETCH); rq.push_back(1'b1);
        sq.push_back(S_DECODE); rq.push_back(1'b0);
        case (kind)
            K_LW: begin
                sq.push_back(S_MEMADR); rq.push_back(1'b0);
                for (int i = 0; i < mw; i++) begin sq.push_back(S_MEMREAD); rq.push_back(1'b0); end
                sq.push_back(S_MEMREAD); rq.push_back(1'b1);
                sq.push_back(S_MEMWB); rq.push_back(1'b0);
            end
            K_SW: begin
                sq.push_back(S_MEMADR); rq.push_back(1'b0);
                for (int i = 0; i < mw; i++) begin sq.push_back(S_MEMWRITE); rq.push_back(1'b0); end
                sq.push_back(S_MEMWRITE); rq.push_back(1'b1);
            end
            K_R:   begin sq.push_back(S_EXECR); rq.push_back(1'b0); sq.push_back(S_ALUWB); rq.push_back(1'b0); end
            K_I:   begin sq.push_back(S_EXECI); rq.push_back(1'b0); sq.push_back(S_ALUWB); rq.push_back(1'b0); end
            K_BEQ: begin sq.push_back(S_BEQ); rq.push_back(1'b0); end
            default: begin sq.push_back(S_JAL); rq.push_back(1'b0); sq.push_back(S_ALUWB); rq.push_back(1'b0); end
        endcase
        for (int i = 0; i < sq.size(); i++) begin
            // Handshake only matters in waiting states; elsewhere it is noise.
            rdy = (sq[i] == S_FETCH || sq[i] == S_MEMREAD || sq[i] == S_MEMWRITE) ? rq[i] : 1'($urandom);
            zz  = (sq[i] == S_BEQ) ? z : 1'($urandom);
            bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7;
            bus.zero = zz; bus.mem_ready = rdy;
            #3;
            exp_v = {4'(sq[i]), ref_imm(op), 1'b0, ref_ctl(sq[i], rdy, zz, op, f3, f7)};
            got_v = {bus.state_o, bus.imm_src, bus.illegal, dut_ctl()};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s step %0d: got state=%0d imm=%b ill=%b ctl=%b, expected state=%0d imm=%b ill=%b ctl=%b",
                         tag, i, got_v[21:18], got_v[17:16], got_v[15], got_v[14:0],
                         exp_v[21:18], exp_v[17:16], exp_v[15], exp_v[14:0]);
            end
            exp_cycles++;
            @(posedge clk); #1;
        end
        exp_instret++;
        n_cmp++;
        if (bus.state_o !== 4'(S_FETCH)) begin
            n_fail++;
            $display("FAIL %s return_to_fetch: got state=%0d expected %0d", tag, bus.state_o, S_FETCH);
        end
`ifdef PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 32'(exp_cycles) || instret_cnt !== 32'(exp_instret)) begin
            n_fail++;
            $display("FAIL %s perf_counts: got cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
                     tag, cycle_cnt, instret_cnt, exp_cycles, exp_instret);
        end
`endif
    endtask

    task automatic test_reset();
        bus.opcode = 7'b0100011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.zero = 1'b1; bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if ({bus.state_o, bus.illegal, dut_ctl(), bus.imm_src} !== {4'd0, 1'b0, 15'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d ill=%b ctl=%b imm=%b expected 0/0/0/01",
                     bus.state_o, bus.illegal, dut_ctl(), bus.imm_src);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.state_o !== 4'd0 || dut_ctl() !== 15'd0) begin
            n_fail++;
            $display("FAIL idle_after_release: got state=%0d ctl=%b expected 0/0", bus.state_o, dut_ctl());
        end
        @(posedge clk); #1;
        exp_cycles = 0; exp_instret = 0;
    endtask

    task automatic test_lw();
        run_instr("lw_nowait", K_LW, 3'b010, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_sw_wait();
        run_instr("sw_wait3", K_SW, 3'b010, 1'b0, 0, 3, 1'b0);
        run_instr("lw_fetchwait", K_LW, 3'b010, 1'b0, 2, 1, 1'b0);
    endtask

    task automatic test_alu_decode();
        run_instr("r_sub", K_R, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr("i_addi", K_I, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr("r_slt", K_R, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr("i_ori", K_I, 3'b110, 1'b1, 0, 0, 1'b0);
        run_instr("r_and", K_R, 3'b111, 1'b0, 0, 0, 1'b0);
        run_instr("jal", K_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", K_BEQ, 3'b000, 1'b0, 0, 0, 1'b1);
        run_instr("beq_not_taken", K_BEQ, 3'b000, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_instr("random", int'($urandom_range(0, 5)), 3'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    task automatic test_illegal();
        bus.opcode = 7'b1110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.state_o !== 4'd2 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_decode: got state=%0d ill=%b expected 2/0", bus.state_o, bus.illegal);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.mem_ready = 1'($urandom); bus.zero = 1'($urandom);
            #1;
            n_cmp++;
            if (bus.state_o !== 4'd15 || bus.illegal !== 1'b1 || dut_ctl() !== 15'd0) begin
                n_fail++;
                $display("FAIL illegal_halt cycle %0d: got state=%0d ill=%b ctl=%b expected 15/1/0",
                         i, bus.state_o, bus.illegal, dut_ctl());
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.state_o !== 4'd0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_reset_clear: got state=%0d ill=%b expected 0/0", bus.state_o, bus.illegal);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_request();
        bus.opcode = 7'b0000011; bus.mem_ready = 1'b0;
        @(posedge clk); #3;
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_wait_req: got mem_req=%b expected 1", bus.mem_req);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_req !== 1'b0 || bus.state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got mem_req=%b state=%0d expected 0/0", bus.mem_req, bus.state_o);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_instr("b2b_r0", K_R, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr("b2b_r1", K_R, 3'b110, 1'b0, 0, 0, 1'b0);
`ifdef PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 32'd8 || instret_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_two_r: got cycle=%0d instret=%0d expected 8/2", cycle_cnt, instret_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_decode();
        test_beq();
        test_illegal();
        test_reset_mid_request();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
